dmux_scan_ctrl: RTL
===================

# dmux_scan_ctrl

Channel scan controller that sits directly upstream of the 1-to-4 demultiplexer. It drives the demux select pair and data line. The block steps the select through channels 0→1→2→3, holding each channel for a programmable dwell time. It supports single-sweep and continuous modes, pause via enable, and sweep-complete signalling.

## Interface
- DWELL, 8, cycles spent on each channel; legal range 1..256.
- iclk  in  1  clock, all state updates on rising edge.
- irst_n  in  1  asynchronous active-low reset.
- ien  in  1  scan enable; low freezes the scan.
- imode  in  1  0 = continuous, 1 = single sweep; sampled only when a scan starts.
- istart  in  1  start request, level-sampled.
- istop  in  1  abort request, level-sampled.
- idata  in  1  data bit routed to the demux data input.
- os1  out  1  select MSB (to demux is1).
- os0  out  1  select LSB (to demux is0).
- oc  out  1  registered data (to demux ic).
- obusy  out  1  high while scanning.
- ostrobe  out  1  one-cycle pulse in the first cycle of each channel dwell.
- osweep_done  out  1  one-cycle pulse after channel 3's dwell completes.

## Operation
- States: IDLE, SCAN. A latched mode bit holds the value of imode captured at start.
- Reset (async, irst_n=0): state IDLE, channel 00, dwell counter 0. All outputs are 0: os1, os0, oc, obusy, ostrobe, osweep_done.
- IDLE:
  - Select is 00, oc=0, obusy=0.
  - istart=1 and istop=0 at an edge moves the block to SCAN.
  - On that transition: channel 00, counter 0, mode latched, ostrobe=1.
  - ien is not required to start a scan.
- SCAN, edge with ien=1:
  - If counter==DWELL-1: counter→0, channel→channel+1 modulo 4, ostrobe=1.
  - Otherwise: counter+1, ostrobe=0.
- Wrap from channel 3 to 0:
  - osweep_done=1 for one cycle in both modes.
  - Single mode: state→IDLE, select 00, obusy=0, and ostrobe stays 0.
  - Continuous mode: the scan continues on channel 00 with ostrobe=1.
- SCAN, edge with ien=0: counter and channel hold; oc, ostrobe and osweep_done are 0. The scan resumes where it stopped once ien returns to 1.
- istop=1 in SCAN: next state is IDLE, select 00, oc 0, no osweep_done. istop overrides ien and a coincident wrap.
- istart while in SCAN is ignored. istart and istop together in IDLE leave the block in IDLE.
- oc is registered: it takes idata at each edge where the next state is SCAN and ien=1, and 0 otherwise.
- The dwell counter is 8 bits wide. With DWELL=1 the channel advances every enabled cycle, and ostrobe stays high throughout continuous scanning.

## Timing
- "Cycle n" is the interval after rising edge n. istart is sampled at edge 0.
- Cycle 0: obusy=1, select 00, ostrobe=1.
- Channel k occupies cycles k·DWELL .. (k+1)·DWELL-1 when ien stays high.
- osweep_done is high in cycle 4·DWELL only.
- Single mode: obusy=0 and select 00 from cycle 4·DWELL.
- Latency from idata to oc is 1 cycle. Select and oc change on the same edge, so the demux sees a consistent {select, data} pair.
- Each cycle with ien low extends the current dwell by exactly one cycle.
- irst_n low mid-scan zeroes all outputs immediately, without waiting for a clock edge. The first valid start is the first edge after deassertion with istart=1.

## Test plan
- Reset, then DWELL=4, single mode, istart pulse at edge 0:
  - {os1,os0} is 00 in cycles 0-3, 01 in 4-7, 10 in 8-11, 11 in 12-15.
  - osweep_done=1 in cycle 16 only; obusy falls in cycle 16.
  - ostrobe is high in cycles 0, 4, 8 and 12.
- Continuous mode, DWELL=2, run 20 cycles:
  - Select returns to 00 at cycles 8 and 16.
  - osweep_done pulses in cycles 8 and 16.
  - obusy stays 1.
- ien low for cycles 5-7 with DWELL=4, single mode:
  - Channel 01 spans cycles 4-10.
  - oc=0 and ostrobe=0 in cycles 6-8.
  - osweep_done is in cycle 19.
- istop asserted at edge 10 during channel 10: cycle 10 has select 00, obusy=0, osweep_done=0. istart together with istop in IDLE keeps obusy=0.
- idata toggling every cycle while scanning: oc in cycle n equals idata before edge n. oc=0 in IDLE.
- irst_n pulled low mid-channel 11: all outputs go to 0 asynchronously. The next istart restarts the scan at channel 00.

Source files
------------

// File: rtl/dmux_scan_ctrl.sv
// Channel scan controller for a 1-to-4 demux: steps the select pair through
// channels 0..3 with a programmable dwell, in single-sweep or continuous mode.
module dmux_scan_ctrl #(
    parameter int unsigned DWELL = 8
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic ien,
    input  logic imode,
    input  logic istart,
    input  logic istop,
    input  logic idata,
    output logic os1,
    output logic os0,
    output logic oc,
    output logic obusy,
    output logic ostrobe,
    output logic osweep_done
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned CH_W  = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(3);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CH_W-1:0]  chan;
    logic [CH_W-1:0]  chan_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             mode;
    logic             mode_n;
    logic             strobe_n;
    logic             done_n;
    logic             oc_n;
    logic             dwell_end_c;
    logic             sweep_end_c;

    assign dwell_end_c = (cnt == CNT_LAST);
    assign sweep_end_c = dwell_end_c && (chan == CH_LAST);

    // State, datapath and output registers
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state       <= IDLE;
            chan        <= '0;
            cnt         <= '0;
            mode        <= 1'b0;
            ostrobe     <= 1'b0;
            osweep_done <= 1'b0;
            oc          <= 1'b0;
        end else begin
            state       <= state_n;
            chan        <= chan_n;
            cnt         <= cnt_n;
            mode        <= mode_n;
            ostrobe     <= strobe_n;
            osweep_done <= done_n;
            oc          <= oc_n;
        end
    end

    // Next-state: start, abort, dwell counting and channel advance
    always_comb begin
        state_n = state;
        chan_n  = chan;
        cnt_n   = cnt;
        mode_n  = mode;
        if (state == IDLE) begin
            if (istart && !istop) begin
                state_n = SCAN;
                chan_n  = '0;
                cnt_n   = '0;
                mode_n  = imode;
            end
        end else begin
            if (istop) begin
                state_n = IDLE;
                chan_n  = '0;
                cnt_n   = '0;
            end else if (ien) begin
                if (dwell_end_c) begin
                    cnt_n  = '0;
                    chan_n = chan + CH_W'(1);
                    if (sweep_end_c && mode) begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
        end
    end

    // Next values of the pulsed outputs and the routed data bit
    always_comb begin
        strobe_n = 1'b0;
        done_n   = 1'b0;
        oc_n     = 1'b0;
        if (state == IDLE) begin
            strobe_n = (state_n == SCAN);
        end else if (!istop && ien) begin
            done_n   = sweep_end_c;
            // A single sweep ending on the wrap does not open a new dwell
            strobe_n = dwell_end_c && !(sweep_end_c && mode);
        end
        if ((state_n == SCAN) && ien) begin
            oc_n = idata;
        end
    end

    assign os1   = chan[1];
    assign os0   = chan[0];
    assign obusy = (state == SCAN);

endmodule
